thiele_cpu_core: RTL and testbench
==================================

// Module: thiele_cpu_core
// PURPOSE
//  Multicycle 32-bit Thiele CPU core. Fetches 32-bit words from an external instruction ROM,
//  executes XOR-algebra/register ops on a 32x32 register file and internal 256x32 data RAM,
//  tracks partition modules, and accumulates mu/info-gain/op counters.
//  Talks to external logic-engine and Python-exec coprocessors via req/ack handshakes.
// PARAMETERS
//  NUM_MODULES  64  module-table entries (lite/synthesis builds use 4)
//  REGION_MAX   8   max elements per module region
// PORTS
//  clk            in   1   clock, rising edge
//  rst_n          in   1   reset, synchronous, active-low
//  instr_data     in   32  instruction word at pc (combinational ROM read, pc[31:2] word index)
//  pc             out  32  byte program counter
//  cert_addr      out  32  last certificate address (logic_data captured on logic_ack)
//  status         out  32  0=reset,1=running,2=halted,3=error
//  error_code     out  32  0=none,1=illegal opcode,2=module table full
//  partition_ops  out  32  count of PNEW executed
//  mdl_ops        out  32  count of MDLACC executed
//  info_gain      out  32  sum of EMIT operand_b values
//  mu             out  32  sum of cost fields of retired instructions
//  mem_addr/mem_wdata out 32, mem_rdata in 32, mem_we/mem_en out 1: legacy bus, driven 0, rdata ignored
//  logic_req out 1, logic_addr out 32, logic_ack in 1, logic_data in 32: logic-engine handshake
//  py_req out 1, py_code_addr out 32, py_ack in 1, py_result in 32: Python-exec handshake
// BEHAVIOUR
//  - Reset (sync): pc, all counters, status, error_code, cert_addr, reqs, reg_file, data_mem,
//    module_table, region_table cleared to 0; state=FETCH.
//  - Instr format: opcode[31:24], operand_a[23:16], operand_b[15:8], cost[7:0]; reg index = operand[4:0].
//  - State encoding (4 bit): FETCH=0, DECODE=1, EXECUTE=2, WAIT_LOGIC=3, WAIT_PY=4, HALTED=5, ERROR=6.
//  - FETCH: latch instr_data, status=1 -> DECODE: register opcode/operand_a/operand_b/cost -> EXECUTE.
//    Internal regs named state, opcode, operand_a, operand_b, reg_file, data_mem, module_table,
//    region_table are hierarchically probed by the bench; keep these names.
//  - EXECUTE (one cycle, then pc+=4, mu+=cost, -> FETCH unless noted):
//    XOR_LOAD 0x0A r[a]<=data_mem[b]; XOR_ADD 0x0B r[a]^=r[b]; XOR_SWAP 0x0C swap r[a],r[b];
//    XFER 0x07 r[a]<=r[b]; XOR_RANK 0x0D r[a]<=popcount(r[b]); EMIT 0x0E info_gain+=b;
//    MDLACC 0x05 mdl_ops++; CHSH_TRIAL 0x09 no state change (bits a[1:0],b[1:0] are trial data);
//    PNEW 0x00 first entry with module_table==0 gets size 1, region[0]=a, partition_ops++;
//      none free -> error 2.
//    LASSERT 0x03 -> WAIT_LOGIC; PYEXEC 0x08 -> WAIT_PY.
//    HALT 0xFF: mu+=cost, pc not advanced, -> HALTED; EXECUTE with opcode HALT lasts exactly 1 cycle.
//    Any other opcode: error_code=1, status=3 -> ERROR.
//  - WAIT_LOGIC: logic_req=1, logic_addr={24'b0,a}; on logic_ack: cert_addr<=logic_data, req=0, retire.
//  - WAIT_PY: py_req=1, py_code_addr={24'b0,a}; on py_ack: r[b]<=py_result, req=0, retire.
//    Waits are unbounded; ack outside wait state ignored.
//  - HALTED: status=2, everything frozen until reset. ERROR: frozen, status=3, error_code held.
//  - Arithmetic: all counters and pc wrap mod 2^32; data_mem index = operand_b[7:0].
//  - Reset mid-wait drops req the next cycle.
// STRUCTURE
//  Shared package: OPCODE_* constants (generated opcode header), state encodings, status/error codes.
//  One sub-module natural: thiele_popcount32 (combinational 32-bit popcount).
// TESTING
//  Default prog (mem[0..3]=29,12,22,03 hex): XOR_LOAD x4, ADD r3^=r0, ADD r3^=r1, SWAP r0/r3, XFER r4<-r2,
//    RANK r5<-r4, EMIT b=4, HALT -> r0=56,r1=18,r2=34,r3=41,r4=34,r5=2, info_gain=4, mu=0,
//    pc=0x28, status=2.
//  Cost field: two EMITs cost 3 and 5 then HALT cost 1 -> mu=9.
//  PNEW a=7 twice -> module_table[0]=1,[1]=1, region[0][0]=7, partition_ops=2; NUM_MODULES+1 PNEWs -> error_code=2.
//  LASSERT with ack 1 cycle after req, logic_data=ABCD1234 -> cert_addr=ABCD1234, req drops, pc+=4.
//  PYEXEC b=6, py_result=12345678 -> r6=12345678; opcode 0x42 -> status=3, error_code=1, pc frozen.
//  Reset asserted during WAIT_PY -> all outputs 0 next cycle, py_req=0.

Source files
------------

// File: rtl/thiele_cpu_core_pkg.sv
// Shared definitions for the Thiele CPU core: opcodes, FSM states, status and error codes.
package thiele_cpu_core_pkg;

  // Opcode map; mirrors the generated opcode header.
  localparam logic [7:0] OPCODE_PNEW       = 8'h00;
  localparam logic [7:0] OPCODE_LASSERT    = 8'h03;
  localparam logic [7:0] OPCODE_MDLACC     = 8'h05;
  localparam logic [7:0] OPCODE_XFER       = 8'h07;
  localparam logic [7:0] OPCODE_PYEXEC     = 8'h08;
  localparam logic [7:0] OPCODE_CHSH_TRIAL = 8'h09;
  localparam logic [7:0] OPCODE_XOR_LOAD   = 8'h0A;
  localparam logic [7:0] OPCODE_XOR_ADD    = 8'h0B;
  localparam logic [7:0] OPCODE_XOR_SWAP   = 8'h0C;
  localparam logic [7:0] OPCODE_XOR_RANK   = 8'h0D;
  localparam logic [7:0] OPCODE_EMIT       = 8'h0E;
  localparam logic [7:0] OPCODE_HALT       = 8'hFF;

  typedef enum logic [3:0] {
    StFetch     = 4'd0,
    StDecode    = 4'd1,
    StExecute   = 4'd2,
    StWaitLogic = 4'd3,
    StWaitPy    = 4'd4,
    StHalted    = 4'd5,
    StError     = 4'd6
  } state_e;

  localparam logic [31:0] STATUS_RESET   = 32'd0;
  localparam logic [31:0] STATUS_RUNNING = 32'd1;
  localparam logic [31:0] STATUS_HALTED  = 32'd2;
  localparam logic [31:0] STATUS_ERROR   = 32'd3;

  localparam logic [31:0] ERR_NONE       = 32'd0;
  localparam logic [31:0] ERR_ILLEGAL    = 32'd1;
  localparam logic [31:0] ERR_TABLE_FULL = 32'd2;

endpackage

// File: rtl/thiele_popcount32.sv
// Combinational population count of a 32-bit word.
module thiele_popcount32 (
  input  logic [31:0] value,
  output logic [5:0]  count
);

  // Sum the set bits.
  always_comb begin
    count = '0;
    for (int i = 0; i < 32; i++) begin
      count = count + 6'(value[i]);
    end
  end

endmodule

// File: rtl/thiele_cpu_core.sv
// Multicycle Thiele CPU core: fetch/decode/execute with coprocessor wait states.
module thiele_cpu_core
  import thiele_cpu_core_pkg::*;
#(
  parameter int unsigned NUM_MODULES = 64,
  parameter int unsigned REGION_MAX  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr_data,
  output logic [31:0] pc,
  output logic [31:0] cert_addr,
  output logic [31:0] status,
  output logic [31:0] error_code,
  output logic [31:0] partition_ops,
  output logic [31:0] mdl_ops,
  output logic [31:0] info_gain,
  output logic [31:0] mu,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        mem_we,
  output logic        mem_en,
  output logic        logic_req,
  output logic [31:0] logic_addr,
  input  logic        logic_ack,
  input  logic [31:0] logic_data,
  output logic        py_req,
  output logic [31:0] py_code_addr,
  input  logic        py_ack,
  input  logic [31:0] py_result
);

  localparam int unsigned ModIdxW = (NUM_MODULES > 1) ? $clog2(NUM_MODULES) : 1;

  state_e      state;
  logic [31:0] instr;
  logic [7:0]  opcode;
  logic [7:0]  operand_a;
  logic [7:0]  operand_b;
  logic [7:0]  cost;
  logic [31:0] reg_file     [32];
  logic [31:0] data_mem     [256];
  logic [31:0] module_table [NUM_MODULES];
  logic [7:0]  region_table [NUM_MODULES][REGION_MAX];

  logic [4:0]         ra;
  logic [4:0]         rb;
  logic [5:0]         rank;
  logic               free_found;
  logic [ModIdxW-1:0] free_idx;
  logic               unused_rdata;

  assign ra = operand_a[4:0];
  assign rb = operand_b[4:0];

  // Legacy memory bus is retired; keep it quiet.
  assign mem_addr     = '0;
  assign mem_wdata    = '0;
  assign mem_we       = 1'b0;
  assign mem_en       = 1'b0;
  assign unused_rdata = ^mem_rdata;

  thiele_popcount32 u_popcount (
    .value(reg_file[rb]),
    .count(rank)
  );

  // Lowest-indexed empty module-table entry.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NUM_MODULES - 1; i >= 0; i--) begin
      if (module_table[i] == 32'd0) begin
        free_found = 1'b1;
        free_idx   = ModIdxW'(i);
      end
    end
  end

  // Core FSM, architectural state and counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= StFetch;
      instr         <= '0;
      opcode        <= '0;
      operand_a     <= '0;
      operand_b     <= '0;
      cost          <= '0;
      pc            <= '0;
      cert_addr     <= '0;
      status        <= STATUS_RESET;
      error_code    <= ERR_NONE;
      partition_ops <= '0;
      mdl_ops       <= '0;
      info_gain     <= '0;
      mu            <= '0;
      logic_req     <= 1'b0;
      logic_addr    <= '0;
      py_req        <= 1'b0;
      py_code_addr  <= '0;
      for (int i = 0; i < 32; i++) reg_file[i] <= '0;
      for (int i = 0; i < 256; i++) data_mem[i] <= '0;
      for (int i = 0; i < NUM_MODULES; i++) begin
        module_table[i] <= '0;
        for (int j = 0; j < REGION_MAX; j++) region_table[i][j] <= '0;
      end
    end else begin
      unique case (state)
        StFetch: begin
          instr  <= instr_data;
          status <= STATUS_RUNNING;
          state  <= StDecode;
        end
        StDecode: begin
          opcode    <= instr[31:24];
          operand_a <= instr[23:16];
          operand_b <= instr[15:8];
          cost      <= instr[7:0];
          state     <= StExecute;
        end
        StExecute: begin
          // Default: retire and fetch the next word; exceptions override below.
          state <= StFetch;
          pc    <= pc + 32'd4;
          mu    <= mu + 32'(cost);
          case (opcode)
            OPCODE_XOR_LOAD: reg_file[ra] <= data_mem[operand_b];
            OPCODE_XOR_ADD:  reg_file[ra] <= reg_file[ra] ^ reg_file[rb];
            OPCODE_XOR_SWAP: begin
              reg_file[ra] <= reg_file[rb];
              reg_file[rb] <= reg_file[ra];
            end
            OPCODE_XFER:       reg_file[ra] <= reg_file[rb];
            OPCODE_XOR_RANK:   reg_file[ra] <= 32'(rank);
            OPCODE_EMIT:       info_gain <= info_gain + 32'(operand_b);
            OPCODE_MDLACC:     mdl_ops <= mdl_ops + 32'd1;
            OPCODE_CHSH_TRIAL: ;
            OPCODE_PNEW: begin
              if (free_found) begin
                module_table[free_idx]    <= 32'd1;
                region_table[free_idx][0] <= operand_a;
                partition_ops             <= partition_ops + 32'd1;
              end else begin
                error_code <= ERR_TABLE_FULL;
                status     <= STATUS_ERROR;
                state      <= StError;
                pc         <= pc;
                mu         <= mu;
              end
            end
            OPCODE_LASSERT: begin
              logic_req  <= 1'b1;
              logic_addr <= {24'b0, operand_a};
              state      <= StWaitLogic;
              pc         <= pc;
              mu         <= mu;
            end
            OPCODE_PYEXEC: begin
              py_req       <= 1'b1;
              py_code_addr <= {24'b0, operand_a};
              state        <= StWaitPy;
              pc           <= pc;
              mu           <= mu;
            end
            OPCODE_HALT: begin
              status <= STATUS_HALTED;
              state  <= StHalted;
              pc     <= pc;
            end
            default: begin
              error_code <= ERR_ILLEGAL;
              status     <= STATUS_ERROR;
              state      <= StError;
              pc         <= pc;
              mu         <= mu;
            end
          endcase
        end
        StWaitLogic: begin
          if (logic_ack) begin
            cert_addr <= logic_data;
            logic_req <= 1'b0;
            pc        <= pc + 32'd4;
            mu        <= mu + 32'(cost);
            state     <= StFetch;
          end
        end
        StWaitPy: begin
          if (py_ack) begin
            reg_file[rb] <= py_result;
            py_req       <= 1'b0;
            pc           <= pc + 32'd4;
            mu           <= mu + 32'(cost);
            state        <= StFetch;
          end
        end
        StHalted: ;
        StError:  ;
        default: begin
          status <= STATUS_ERROR;
          state  <= StError;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_thiele_cpu_core.sv
// Self-checking bench for thiele_cpu_core: directed cases plus random programs vs an ISA model.
module tb_thiele_cpu_core;

  localparam int unsigned NumModules = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr_data, pc, cert_addr, status, error_code, partition_ops, mdl_ops;
  logic [31:0] info_gain, mu, mem_addr, mem_wdata, mem_rdata, logic_addr, logic_data;
  logic [31:0] py_code_addr, py_result;
  logic        mem_we, mem_en, logic_req, logic_ack, py_req, py_ack;

  logic [31:0] rom [128];
  logic [31:0] l_table [256];
  logic [31:0] p_table [256];
  int          ldelay = 0, pdelay = 0, lwait = 0, pwait = 0;
  bit          py_hold = 0;
  int          n_cmp = 0, n_fail = 0;

  // ISA-level model state
  logic [31:0] m_reg [32];
  logic [31:0] m_mem [256];
  logic [31:0] m_pc, m_mu, m_ig, m_mdl, m_part, m_cert, m_status, m_err;
  int          m_mods;

  assign instr_data = rom[pc[8:2]];
  assign mem_rdata  = 32'hDEAD_BEEF;

  always #5 clk = ~clk;

  thiele_cpu_core #(.NUM_MODULES(NumModules), .REGION_MAX(8)) dut (
    .clk(clk), .rst_n(rst_n), .instr_data(instr_data), .pc(pc), .cert_addr(cert_addr),
    .status(status), .error_code(error_code), .partition_ops(partition_ops),
    .mdl_ops(mdl_ops), .info_gain(info_gain), .mu(mu), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_we(mem_we), .mem_en(mem_en),
    .logic_req(logic_req), .logic_addr(logic_addr), .logic_ack(logic_ack),
    .logic_data(logic_data), .py_req(py_req), .py_code_addr(py_code_addr),
    .py_ack(py_ack), .py_result(py_result)
  );

  // Logic-engine responder: ack after ldelay cycles of observed request.
  initial begin
    logic_ack = 1'b0;
    logic_data = '0;
    forever begin
      @(negedge clk);
      if (logic_req && !logic_ack) begin
        if (lwait >= ldelay) begin
          logic_ack = 1'b1;
          logic_data = l_table[logic_addr[7:0]];
          lwait = 0;
        end else lwait++;
      end else begin
        logic_ack = 1'b0;
        lwait = 0;
      end
    end
  end

  // Python-exec responder; py_hold stalls it indefinitely.
  initial begin
    py_ack = 1'b0;
    py_result = '0;
    forever begin
      @(negedge clk);
      if (py_req && !py_ack && !py_hold) begin
        if (pwait >= pdelay) begin
          py_ack = 1'b1;
          py_result = p_table[py_code_addr[7:0]];
          pwait = 0;
        end else pwait++;
      end else begin
        py_ack = 1'b0;
        pwait = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 128; i++) rom[i] = 32'hFF00_0000;
  endtask

  // Reset, then preload data memory from m_mem as reset is released.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 256; i++) dut.data_mem[i] = m_mem[i];
  endtask

  task automatic run_prog(input int budget);
    int c;
    c = 0;
    while (!(status == 32'd2 || status == 32'd3) && c < budget) begin
      @(negedge clk);
      c++;
    end
    check("run_completes", 32'(c < budget), 32'd1);
    repeat (4) @(negedge clk);
  endtask

  // Architectural interpreter: one instruction per iteration, no pipeline notion.
  task automatic model_run();
    logic [31:0] w, t;
    logic [7:0]  op, a, b, c;
    bit          done;
    m_pc = 0; m_mu = 0; m_ig = 0; m_mdl = 0; m_part = 0; m_cert = 0;
    m_status = 1; m_err = 0; m_mods = 0;
    for (int i = 0; i < 32; i++) m_reg[i] = '0;
    done = 0;
    for (int s = 0; s < 500 && !done; s++) begin
      w = rom[m_pc[8:2]];
      {op, a, b, c} = w;
      case (op)
        8'h0A: m_reg[a[4:0]] = m_mem[b];
        8'h0B: m_reg[a[4:0]] = m_reg[a[4:0]] ^ m_reg[b[4:0]];
        8'h0C: begin
          t = m_reg[a[4:0]];
          m_reg[a[4:0]] = m_reg[b[4:0]];
          m_reg[b[4:0]] = t;
        end
        8'h07: m_reg[a[4:0]] = m_reg[b[4:0]];
        8'h0D: m_reg[a[4:0]] = 32'($countones(m_reg[b[4:0]]));
        8'h0E: m_ig = m_ig + 32'(b);
        8'h05: m_mdl = m_mdl + 1;
        8'h09: ;
        8'h00: begin
          if (m_mods < NumModules) begin
            m_mods++;
            m_part = m_part + 1;
          end else begin
            m_status = 3; m_err = 2; done = 1;
          end
        end
        8'h03: m_cert = l_table[a];
        8'h08: m_reg[b[4:0]] = p_table[a];
        8'hFF: begin
          m_mu = m_mu + 32'(c); m_status = 2; done = 1;
        end
        default: begin
          m_status = 3; m_err = 1; done = 1;
        end
      endcase
      if (!done) begin
        m_pc = m_pc + 4;
        m_mu = m_mu + 32'(c);
      end
    end
  endtask

  task automatic compare_all(input string pfx);
    model_run();
    check({pfx, ".pc"}, pc, m_pc);
    check({pfx, ".mu"}, mu, m_mu);
    check({pfx, ".info_gain"}, info_gain, m_ig);
    check({pfx, ".mdl_ops"}, mdl_ops, m_mdl);
    check({pfx, ".partition_ops"}, partition_ops, m_part);
    check({pfx, ".cert_addr"}, cert_addr, m_cert);
    check({pfx, ".status"}, status, m_status);
    check({pfx, ".error_code"}, error_code, m_err);
    check({pfx, ".logic_req"}, 32'(logic_req), 32'd0);
    check({pfx, ".py_req"}, 32'(py_req), 32'd0);
    for (int i = 0; i < 32; i++) check($sformatf("%s.r%0d", pfx, i), dut.reg_file[i], m_reg[i]);
  endtask

  initial begin
    logic [7:0] ops [11];
    logic [31:0] w;
    int len;
    ops = '{8'h0A, 8'h0B, 8'h0C, 8'h07, 8'h0D, 8'h0E, 8'h05, 8'h09, 8'h00, 8'h03, 8'h08};
    for (int i = 0; i < 256; i++) begin
      l_table[i] = $urandom;
      p_table[i] = $urandom;
      m_mem[i] = '0;
    end
    clear_rom();

    // Reset state, sampled while reset is held.
    repeat (3) @(negedge clk);
    check("rst.pc", pc, 32'd0);
    check("rst.status", status, 32'd0);
    check("rst.mu", mu, 32'd0);
    check("rst.error_code", error_code, 32'd0);
    check("rst.state", 32'(dut.state), 32'd0);
    check("rst.mem_en", 32'({mem_en, mem_we}), 32'd0);

    // Default program.
    m_mem[0] = 32'h29; m_mem[1] = 32'h12; m_mem[2] = 32'h22; m_mem[3] = 32'h03;
    rom[0] = 32'h0A00_0000; rom[1] = 32'h0A01_0100; rom[2] = 32'h0A02_0200;
    rom[3] = 32'h0A03_0300; rom[4] = 32'h0B03_0000; rom[5] = 32'h0B03_0100;
    rom[6] = 32'h0C00_0300; rom[7] = 32'h0704_0200; rom[8] = 32'h0D05_0400;
    rom[9] = 32'h0E00_0400;
    do_reset();
    run_prog(200);
    check("dflt.r0", dut.reg_file[0], 32'd56);
    check("dflt.r1", dut.reg_file[1], 32'd18);
    check("dflt.r2", dut.reg_file[2], 32'd34);
    check("dflt.r3", dut.reg_file[3], 32'd41);
    check("dflt.r4", dut.reg_file[4], 32'd34);
    check("dflt.r5", dut.reg_file[5], 32'd2);
    check("dflt.pc", pc, 32'h28);
    check("dflt.status", status, 32'd2);
    check("dflt.state", 32'(dut.state), 32'd5);
    compare_all("dflt");
    for (int i = 0; i < 4; i++) m_mem[i] = '0;

    // Cost accumulation.
    clear_rom();
    rom[0] = 32'h0E00_0103; rom[1] = 32'h0E00_0205; rom[2] = 32'hFF00_0001;
    do_reset();
    run_prog(100);
    check("cost.mu", mu, 32'd9);
    compare_all("cost");

    // Two PNEWs.
    clear_rom();
    rom[0] = 32'h0007_0000; rom[1] = 32'h0007_0000;
    do_reset();
    run_prog(100);
    check("pnew.mt0", dut.module_table[0], 32'd1);
    check("pnew.mt1", dut.module_table[1], 32'd1);
    check("pnew.mt2", dut.module_table[2], 32'd0);
    check("pnew.region00", 32'(dut.region_table[0][0]), 32'd7);
    check("pnew.region10", 32'(dut.region_table[1][0]), 32'd7);
    check("pnew.parts", partition_ops, 32'd2);

    // Module table overflow.
    clear_rom();
    for (int i = 0; i <= NumModules; i++) rom[i] = 32'h0003_0001;
    do_reset();
    run_prog(1000);
    check("full.error_code", error_code, 32'd2);
    check("full.status", status, 32'd3);
    check("full.parts", partition_ops, NumModules);
    check("full.pc", pc, 32'(NumModules * 4));
    compare_all("full");

    // LASSERT with one-cycle ack delay.
    clear_rom();
    rom[0] = 32'h0311_0000;
    l_table[8'h11] = 32'hABCD_1234;
    ldelay = 1;
    do_reset();
    run_prog(100);
    check("lassert.cert", cert_addr, 32'hABCD_1234);
    check("lassert.addr", logic_addr, 32'h11);
    check("lassert.pc", pc, 32'd4);
    check("lassert.req", 32'(logic_req), 32'd0);

    // PYEXEC into r6.
    clear_rom();
    rom[0] = 32'h0800_0600;
    p_table[0] = 32'h1234_5678;
    pdelay = 2;
    do_reset();
    run_prog(100);
    check("pyexec.r6", dut.reg_file[6], 32'h1234_5678);
    compare_all("pyexec");

    // Illegal opcode freezes the core.
    clear_rom();
    rom[0] = 32'h0E00_0102; rom[1] = 32'h4200_0000;
    do_reset();
    run_prog(100);
    repeat (5) @(negedge clk);
    check("illegal.status", status, 32'd3);
    check("illegal.error_code", error_code, 32'd1);
    check("illegal.pc", pc, 32'd4);
    check("illegal.mu", mu, 32'd2);
    check("illegal.state", 32'(dut.state), 32'd6);

    // Reset while stalled in WAIT_PY.
    clear_rom();
    rom[0] = 32'h0E00_0209; rom[1] = 32'h0801_0200;
    py_hold = 1;
    do_reset();
    begin
      int c;
      c = 0;
      while (!py_req && c < 100) begin
        @(negedge clk);
        c++;
      end
      check("pyrst.req_seen", 32'(py_req), 32'd1);
      check("pyrst.code_addr", py_code_addr, 32'd1);
    end
    rst_n = 1'b0;
    @(negedge clk);
    check("pyrst.py_req", 32'(py_req), 32'd0);
    check("pyrst.py_code_addr", py_code_addr, 32'd0);
    check("pyrst.pc", pc, 32'd0);
    check("pyrst.mu", mu, 32'd0);
    check("pyrst.info_gain", info_gain, 32'd0);
    check("pyrst.status", status, 32'd0);
    py_hold = 0;

    // Random programs against the ISA model.
    for (int p = 0; p < 20; p++) begin
      clear_rom();
      for (int i = 0; i < 256; i++) begin
        m_mem[i] = $urandom;
        l_table[i] = $urandom;
        p_table[i] = $urandom;
      end
      len = $urandom_range(4, 24);
      for (int i = 0; i < len; i++) begin
        w = $urandom;
        if ($urandom_range(0, 29) == 0) w[31:24] = 8'h42;
        else w[31:24] = ops[$urandom_range(0, 10)];
        rom[i] = w;
      end
      rom[len] = {8'hFF, 16'h0, 8'($urandom)};
      ldelay = $urandom_range(0, 3);
      pdelay = $urandom_range(0, 3);
      do_reset();
      run_prog(2000);
      compare_all($sformatf("rand%0d", p));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
